instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the program counter and drives `PC` into Instruction_Memory each cycle.
- Captures the returned `Instruction` into the IF/ID pipeline register.
- Supports pipeline stall, flush, and taken-branch redirect from later stages.
- Sits at the head of the pipelined datapath, feeding the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- NOP_INSTR, 32'h00000000, instruction word inserted on flush/bubble (sll $0,$0,0).

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit request to hold PC and IF/ID.
- flush  input  1  squash the IF/ID contents (insert bubble).
- branch_taken  input  1  redirect fetch to branch_target.
- branch_target  input  32  redirect address from EX/ID.
- Instruction  input  32  word returned by Instruction_Memory for the current `PC` (combinational read, same cycle).
- PC  output  32  fetch address to Instruction_Memory.
- IF_ID_Instr  output  32  registered instruction to decode.
- IF_ID_PC4  output  32  registered PC+PC_STEP of that instruction.
- IF_ID_valid  output  1  IF_ID_Instr holds a real fetched instruction.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_valid=0.
  - Outputs change immediately on reset assertion, without waiting for an edge.
- First rising edge after reset deasserts: the instruction at RESET_PC is captured and IF_ID_valid goes to 1. Latency from `PC` to IF/ID outputs is exactly 1 clock.
- PC next-state, evaluated at each rising edge, in priority order:
  1. branch_taken=1 → PC = {branch_target[31:2],2'b00}. This applies even when stall=1, so a redirect is never lost.
  2. stall=1 → PC holds.
  3. Otherwise → PC = PC+PC_STEP. Arithmetic is modulo 2^32, so 32'hFFFFFFFC+4 wraps to 0.
- IF/ID next-state, evaluated at each rising edge, in priority order:
  1. flush=1 or branch_taken=1 → IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_valid=0. This overrides stall.
  2. stall=1 → all IF/ID outputs hold their values.
  3. Otherwise → IF_ID_Instr=Instruction, IF_ID_PC4=PC+PC_STEP (same wrap rule), IF_ID_valid=1.
- Misaligned branch_target: the low 2 bits are silently cleared; no error is flagged.
- Sustained stall: PC and IF/ID are frozen indefinitely. `Instruction` is ignored while stalled, so no fetch is consumed.
- Simultaneous stall and flush without branch: PC holds and a bubble is inserted; the held PC is fetched again once stall drops.
- No combinational path from any input to `PC`; `PC` is a pure register output.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - fetch_count (32 bits): increments on every edge where IF/ID loads with valid=1.
  - stall_count (32 bits): increments on every edge where stall=1 and no flush/branch is asserted.
- Both counters reset to 0 on reset and wrap modulo 2^32.
- When not defined, the ports and counters are absent and the block has no extra logic.

Test Plan:
- Reset then free-run 6 cycles with memory returning word = PC|32'hA0000000:
  - PC sequence 0,4,8,12,16,20.
  - IF_ID_Instr lags one cycle (A0000000, A0000004, …).
  - IF_ID_PC4 = 4, 8, 12, …
  - IF_ID_valid goes 0→1 at the first edge.
- Stall asserted for 3 cycles at PC=8:
  - PC stays 8 and IF/ID holds the PC=4 instruction during those cycles.
  - After release, PC goes 12 and IF_ID_Instr = A0000008.
- branch_taken with target 32'h00000041 at PC=16:
  - Next PC=0x40 and IF_ID_valid=0 with NOP_INSTR.
  - The following edge captures the word at 0x40.
- branch_taken and stall together at PC=20: PC redirects to the target (not held) and IF/ID is flushed.
- Wrap test: force the redirect target to 32'hFFFFFFFC, then free-run; the next PC is 0 and IF_ID_PC4=0.
- Reset pulse mid-stall: PC returns to RESET_PC immediately and IF_ID_valid=0. If FETCH_PERF_CNT_EN is defined, both counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction-fetch stage. Owns the program counter, presents it to the
//   instruction memory (combinational read) and captures the returned word
//   into the IF/ID pipeline register. Honours stall, flush and taken-branch
//   redirect coming from later stages.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   PC_STEP    sequential PC increment in bytes
//   NOP_INSTR  word inserted into IF/ID on a bubble
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold PC and IF/ID
//   flush          squash IF/ID (insert bubble)
//   branch_taken   redirect fetch to branch_target (also squashes IF/ID)
//   branch_target  redirect address; low two bits are ignored
//   Instruction    word read from instruction memory at PC
//   PC             fetch address (pure register output)
//   IF_ID_Instr    registered instruction for decode
//   IF_ID_PC4      registered PC+PC_STEP of that instruction
//   IF_ID_valid    IF_ID_Instr holds a real fetched instruction
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_count    number of edges on which IF/ID loaded a valid word
//   stall_count    number of edges stalled with no flush/branch pending
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned PC_STEP   = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instr,
   output logic [31:0] IF_ID_PC4,
   output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   logic [31:0] pc_seq;
   logic        bubble;
   logic        load;

   // Sequential PC wraps naturally modulo 2^32.
   assign pc_seq = PC + STEP;
   // A taken branch squashes the wrong-path word already fetched.
   assign bubble = flush | branch_taken;
   assign load   = ~bubble & ~stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PC <= RESET_PC;
      end else if (branch_taken) begin
         // Redirect beats stall so a resolved branch is never dropped.
         PC <= {branch_target[31:2], 2'b00};
      end else if (!stall) begin
         PC <= pc_seq;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IF_ID_Instr <= NOP_INSTR;
         IF_ID_PC4   <= '0;
         IF_ID_valid <= 1'b0;
      end else if (bubble) begin
         IF_ID_Instr <= NOP_INSTR;
         IF_ID_PC4   <= '0;
         IF_ID_valid <= 1'b0;
      end else if (load) begin
         IF_ID_Instr <= Instruction;
         IF_ID_PC4   <= pc_seq;
         IF_ID_valid <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (load)
            fetch_count <= fetch_count + 32'd1;
         if (stall && !bubble)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. The instruction memory returns
//   addr | 32'hA0000000. A behavioural model tracks the architectural state
//   and is compared against the DUT on every falling edge; directed steps
//   additionally check hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instr;
   logic [31:0] IF_ID_PC4;
   logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int vectors = 0;
   int miscompares = 0;
   bit compare_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr | 32'hA000_0000;
   endfunction

   assign Instruction = mem_word(PC);

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4),
      .NOP_INSTR(32'h0000_0000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .Instruction  (Instruction),
      .PC           (PC),
      .IF_ID_Instr  (IF_ID_Instr),
      .IF_ID_PC4    (IF_ID_PC4),
      .IF_ID_valid  (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count  (fetch_count),
      .stall_count  (stall_count)
`endif
   );

   // Behavioural model: architectural state of the fetch stage.
   logic [31:0] m_pc = '0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc4 = '0;
   logic        m_valid = 1'b0;
   logic [31:0] m_fetches = '0;
   logic [31:0] m_stalls = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc      <= 32'h0;
         m_instr   <= 32'h0;
         m_pc4     <= 32'h0;
         m_valid   <= 1'b0;
         m_fetches <= 32'h0;
         m_stalls  <= 32'h0;
      end else begin
         if (branch_taken)
            m_pc <= branch_target & 32'hFFFF_FFFC;
         else if (!stall)
            m_pc <= m_pc + 32'd4;
         if (flush || branch_taken) begin
            m_instr <= 32'h0;
            m_pc4   <= 32'h0;
            m_valid <= 1'b0;
         end else if (!stall) begin
            m_instr   <= mem_word(m_pc);
            m_pc4     <= m_pc + 32'd4;
            m_valid   <= 1'b1;
            m_fetches <= m_fetches + 32'd1;
         end else begin
            m_stalls <= m_stalls + 32'd1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (compare_en) begin
         check("cyc PC", PC, m_pc);
         check("cyc IF_ID_Instr", IF_ID_Instr, m_instr);
         check("cyc IF_ID_PC4", IF_ID_PC4, m_pc4);
         check("cyc IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
         check("cyc fetch_count", fetch_count, m_fetches);
         check("cyc stall_count", stall_count, m_stalls);
`endif
      end
   end

   // Apply inputs for one edge, then wait until just after it.
   task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
      stall = st;
      flush = fl;
      branch_taken = br;
      branch_target = tgt;
      @(posedge clk);
      #2;
   endtask

   task automatic expect_state(input string name, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] pc4, input logic v);
      check({name, " PC"}, PC, pc);
      check({name, " Instr"}, IF_ID_Instr, ins);
      check({name, " PC4"}, IF_ID_PC4, pc4);
      check({name, " valid"}, {31'b0, IF_ID_valid}, {31'b0, v});
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      compare_en = 1'b1;

      // Free run: PC 0 -> 4 -> 8, IF/ID lags by one.
      step(0, 0, 0, 0);
      expect_state("run1", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
      step(0, 0, 0, 0);
      expect_state("run2", 32'h8, 32'hA000_0004, 32'h8, 1'b1);

      // Stall for three edges at PC=8.
      for (int unsigned i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         expect_state("stall", 32'h8, 32'hA000_0004, 32'h8, 1'b1);
      end
      step(0, 0, 0, 0);
      expect_state("release", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
      step(0, 0, 0, 0);
      expect_state("run3", 32'h10, 32'hA000_000C, 32'h10, 1'b1);

      // Misaligned branch target at PC=16.
      step(0, 0, 1, 32'h0000_0041);
      expect_state("branch", 32'h40, 32'h0, 32'h0, 1'b0);
      step(0, 0, 0, 0);
      expect_state("post_branch", 32'h44, 32'hA000_0040, 32'h44, 1'b1);

      // Branch together with stall: redirect wins, IF/ID flushed.
      step(1, 0, 1, 32'h0000_0100);
      expect_state("br_stall", 32'h100, 32'h0, 32'h0, 1'b0);

      // Wrap: redirect to the top word, then free-run.
      step(0, 0, 1, 32'hFFFF_FFFC);
      expect_state("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      step(0, 0, 0, 0);
      expect_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

      // Stall + flush: PC held, bubble inserted; held PC refetched later.
      step(1, 1, 0, 0);
      expect_state("stall_flush", 32'h0, 32'h0, 32'h0, 1'b0);
      step(0, 0, 0, 0);
      expect_state("refetch", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

      // Plain flush without stall.
      step(0, 1, 0, 0);
      expect_state("flush", 32'h8, 32'h0, 32'h0, 1'b0);

      // Randomized traffic, checked every cycle by the model.
      for (int unsigned i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 99) < 10), $urandom);
      end

      // Reset pulse in the middle of a stall, asserted away from an edge.
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      #1 reset = 1'b1;
      #1;
      expect_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      check("mid_reset fetch_count", fetch_count, 32'h0);
      check("mid_reset stall_count", stall_count, 32'h0);
`endif
      @(posedge clk);
      #2 reset = 1'b0;
      stall = 1'b0;
      step(0, 0, 0, 0);
      expect_state("after_reset", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
      step(0, 0, 0, 0);

      compare_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
